// File: rtl/if_id_stage.sv
// ----------------------------------------------------------------------------
// if_id_stage
//
// Registered fetch-to-decode pipeline stage with a valid/ready handshake. It
// uses a two-entry skid buffer, so in_ready can be a registered signal and
// still sustain one instruction per cycle. Decode always sees the main entry.
// The skid entry only catches the single instruction that was accepted in the
// cycle when decode stalled.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   reset      - asynchronous, active-high reset
//   in_valid   - fetch presents a valid instruction
//   in_ready   - stage can accept (registered, == !skid_valid)
//   in_instr   - 32-bit instruction word from fetch
//   in_pc      - PC of in_instr
//   flush      - synchronous discard of every held entry (branch/jump redirect)
//   out_valid  - main entry holds a valid instruction
//   out_ready  - decode consumes the main entry
//   out_instr  - held instruction word
//   out_pc     - held PC
//   out_opcode - out_instr[31:26]
//   out_rs     - out_instr[25:21]
//   out_rt     - out_instr[20:16]
//   out_imm16  - out_instr[15:0], the 16-bit input of the sign extender
// ----------------------------------------------------------------------------
module if_id_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [15:0]       out_imm16
);

  // The encoding is {skid_valid, main_valid}, so both valids are plain
  // state bits. 2'b10 (skid without main) is unreachable.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b11
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]       r_main_instr;
  logic [ADDR_W-1:0] r_main_pc;
  logic [31:0]       r_skid_instr;
  logic [ADDR_W-1:0] r_skid_pc;

  logic w_main_valid;
  logic w_skid_valid;
  logic w_acc;
  logic w_pop;
  logic w_load_main_in;    // main <- input
  logic w_load_main_skid;  // main <- skid
  logic w_load_skid_in;    // skid <- input

  assign w_main_valid = r_state[0];
  assign w_skid_valid = r_state[1];

  // Both handshake outputs are taken straight from state bits. This gives no
  // combinational path from in_valid to out_valid or from out_ready to in_ready.
  assign in_ready  = ~w_skid_valid;
  assign out_valid = w_main_valid;

  assign w_acc = in_valid & in_ready;
  assign w_pop = w_main_valid & out_ready;

  // Next-state and data-load control
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid_in   = 1'b0;

    case (r_state)
      S_EMPTY: begin
        if (w_acc) begin
          w_load_main_in = 1'b1;
          w_state_next   = S_ONE;
        end
      end
      S_ONE: begin
        if (w_acc && w_pop) begin
          w_load_main_in = 1'b1;
        end else if (w_acc) begin
          w_load_skid_in = 1'b1;
          w_state_next   = S_FULL;
        end else if (w_pop) begin
          w_state_next = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so no accept can occur.
        if (w_pop) begin
          w_load_main_skid = 1'b1;
          w_state_next     = S_ONE;
        end
      end
      default: begin
        w_state_next = S_EMPTY;
      end
    endcase

    // A redirect wins over everything. Any accept in this cycle is dropped.
    // Any pop in this cycle still counts as consumed by decode.
    if (flush) begin
      w_state_next     = S_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The data registers change only when their entry is written. A pop or a
  // flush leaves the stale data in place, because only the valids matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_instr <= '0;
      r_main_pc    <= '0;
    end else if (w_load_main_in) begin
      r_main_instr <= in_instr;
      r_main_pc    <= in_pc;
    end else if (w_load_main_skid) begin
      r_main_instr <= r_skid_instr;
      r_main_pc    <= r_skid_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (w_load_skid_in) begin
      r_skid_instr <= in_instr;
      r_skid_pc    <= in_pc;
    end
  end

  assign out_instr  = r_main_instr;
  assign out_pc     = r_main_pc;
  assign out_opcode = r_main_instr[31:26];
  assign out_rs     = r_main_instr[25:21];
  assign out_rt     = r_main_instr[20:16];
  assign out_imm16  = r_main_instr[15:0];

endmodule

// File: tb/tb_if_id_stage.sv
// ----------------------------------------------------------------------------
// tb_if_id_stage
//
// Directed testbench for if_id_stage. Inputs are driven on the falling edge.
// Outputs are sampled on the falling edge, before the new inputs are applied.
// ----------------------------------------------------------------------------
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [15:0] out_imm16;

  int n_cmp;
  int n_bad;

  if_id_stage #(.ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_imm16  (out_imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, ".valid"},  {31'd0, out_valid}, 32'd1);
    chk({tag, ".pc"},     out_pc, pc);
    chk({tag, ".instr"},  out_instr, ins);
    chk({tag, ".opcode"}, {26'd0, out_opcode}, {26'd0, ins[31:26]});
    chk({tag, ".rs"},     {27'd0, out_rs}, {27'd0, ins[25:21]});
    chk({tag, ".rt"},     {27'd0, out_rt}, {27'd0, ins[20:16]});
    chk({tag, ".imm16"},  {16'd0, out_imm16}, {16'd0, ins[15:0]});
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  logic [31:0] sw_instr [0:9];
  logic [31:0] sext;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

    // ---- reset state ----
    @(negedge clk);
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst.out_instr", out_instr, 32'd0);
    chk("rst.out_pc",    out_pc, 32'd0);
    reset = 1'b0;
    $display("reset released");

    // ---- streaming, out_ready=1 ----
    @(negedge clk);
    drive(1'b1, 32'h2001FFFC, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("s0.opcode", {26'd0, out_opcode}, 32'h08);
    chk("s0.rs",     {27'd0, out_rs}, 32'd0);
    chk("s0.rt",     {27'd0, out_rt}, 32'd1);
    chk("s0.imm16",  {16'd0, out_imm16}, 32'hFFFC);
    chk("s0.pc",     out_pc, 32'h0);
    chk("s0.in_ready", {31'd0, in_ready}, 32'd1);
    $display("stream pc=0 instr=2001FFFC");
    drive(1'b1, 32'h3C021234, 32'h4, 1'b1, 1'b0);
    @(negedge clk);
    chk("s1.opcode", {26'd0, out_opcode}, 32'h0F);
    chk("s1.rt",     {27'd0, out_rt}, 32'd2);
    chk("s1.imm16",  {16'd0, out_imm16}, 32'h1234);
    chk("s1.pc",     out_pc, 32'h4);
    chk("s1.in_ready", {31'd0, in_ready}, 32'd1);
    $display("stream pc=4 instr=3C021234");
    drive(1'b1, 32'h8C43FFFF, 32'h8, 1'b1, 1'b0);
    @(negedge clk);
    chk("s2.opcode", {26'd0, out_opcode}, 32'h23);
    chk("s2.rs",     {27'd0, out_rs}, 32'd2);
    chk("s2.rt",     {27'd0, out_rt}, 32'd3);
    chk("s2.pc",     out_pc, 32'h8);
    chk("s2.in_ready", {31'd0, in_ready}, 32'd1);
    $display("stream pc=8 instr=8C43FFFF");
    drive(1'b1, 32'hAC430008, 32'hC, 1'b1, 1'b0);
    @(negedge clk);
    chk("s3.opcode", {26'd0, out_opcode}, 32'h2B);
    chk("s3.imm16",  {16'd0, out_imm16}, 32'h0008);
    chk("s3.pc",     out_pc, 32'hC);
    chk("s3.valid",  {31'd0, out_valid}, 32'd1);
    $display("stream pc=C instr=AC430008");
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("s.drain_valid", {31'd0, out_valid}, 32'd0);

    // ---- backpressure ----
    drive(1'b1, 32'h1111000A, 32'hA, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp.a_pc", out_pc, 32'hA);
    chk("bp.a_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h1111000B, 32'hB, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp.full_ready", {31'd0, in_ready}, 32'd0);
    chk("bp.full_pc", out_pc, 32'hA);
    drive(1'b1, 32'h1111000C, 32'hC, 1'b0, 1'b0);
    @(negedge clk);
    chk("bp.hold_ready", {31'd0, in_ready}, 32'd0);
    chk("bp.hold_pc", out_pc, 32'hA);
    drive(1'b1, 32'h1111000C, 32'hC, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp.b_pc", out_pc, 32'hB);
    chk("bp.b_instr", out_instr, 32'h1111000B);
    chk("bp.b_ready", {31'd0, in_ready}, 32'd1);
    $display("backpressure pc=B popped from skid");
    drive(1'b1, 32'h1111000C, 32'hC, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp.c_pc", out_pc, 32'hC);
    chk("bp.c_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("bp.drain_valid", {31'd0, out_valid}, 32'd0);

    // ---- flush in FULL with in_valid=1 ----
    drive(1'b1, 32'h22220020, 32'h20, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h22220024, 32'h24, 1'b0, 1'b0);
    @(negedge clk);
    chk("fl.full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'h22220028, 32'h28, 1'b0, 1'b1);
    @(negedge clk);
    chk("fl.valid", {31'd0, out_valid}, 32'd0);
    chk("fl.ready", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'h22220040, 32'h40, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl.first_pc", out_pc, 32'h40);
    chk("fl.first_valid", {31'd0, out_valid}, 32'd1);
    $display("flush-full: first output pc=40");
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl.after_valid", {31'd0, out_valid}, 32'd0);

    // ---- flush with simultaneous pop in ONE (and an accept to discard) ----
    drive(1'b1, 32'h33330050, 32'h50, 1'b0, 1'b0);
    @(negedge clk);
    chk("fp.one_pc", out_pc, 32'h50);
    drive(1'b1, 32'h33330054, 32'h54, 1'b1, 1'b1);
    @(negedge clk);
    chk("fp.valid", {31'd0, out_valid}, 32'd0);
    chk("fp.ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fp.no_replay", {31'd0, out_valid}, 32'd0);
    $display("flush-pop: no replay");

    // ---- field sweep ----
    sw_instr[0] = 32'h12348000;
    sw_instr[1] = 32'h56787FFF;
    for (int i = 2; i < 10; i++) sw_instr[i] = $urandom;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, sw_instr[i], 32'h100 + 32'(i * 4), 1'b1, 1'b0);
      @(negedge clk);
      chk_fields("sweep", sw_instr[i], 32'h100 + 32'(i * 4));
      $display("sweep pc=%h instr=%h", out_pc, out_instr);
      if (i == 0) begin
        sext = {{16{out_imm16[15]}}, out_imm16};
        chk("sweep.sext8000", sext, 32'hFFFF8000);
      end
      if (i == 1) begin
        sext = {{16{out_imm16[15]}}, out_imm16};
        chk("sweep.sext7FFF", sext, 32'h00007FFF);
      end
    end
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);

    // ---- asynchronous reset mid-cycle with both entries full ----
    drive(1'b1, 32'h44440060, 32'h60, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'h44440064, 32'h64, 1'b0, 1'b0);
    @(negedge clk);
    chk("ar.full_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("ar.out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("ar.out_instr", out_instr, 32'd0);
    chk("ar.out_pc",    out_pc, 32'd0);
    $display("async reset applied");
    @(negedge clk);
    reset = 1'b0;
    drive(1'b1, 32'h55550070, 32'h70, 1'b1, 1'b0);
    @(negedge clk);
    chk("ar.first_pc", out_pc, 32'h70);
    chk("ar.first_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clk);
    chk("ar.drain_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Registered fetch-to-decode pipeline stage with a valid/ready handshake. It accepts a 32-bit instruction word and its PC from fetch, holds them in a two-entry skid buffer, and presents the decoded fields to decode. The 16-bit immediate field is one of those fields and drives the immediate input of the sign extender. `flush` discards everything in flight on a branch or jump redirect.

## Interface
Parameters:
- `ADDR_W`, default 32: PC width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: reset is asynchronous and active-high.
- `in_valid`, input, 1: fetch presents a valid instruction.
- `in_ready`, output, 1: stage can accept. Registered; equals `!skid_valid`.
- `in_instr`, input, 32: instruction word.
- `in_pc`, input, ADDR_W: PC of `in_instr`.
- `flush`, input, 1: synchronous discard of all held entries.
- `out_valid`, output, 1: the main entry holds a valid instruction.
- `out_ready`, input, 1: decode consumes the main entry.
- `out_instr`, output, 32: the held instruction word.
- `out_pc`, output, ADDR_W: the held PC.
- `out_opcode`, output, 6: `out_instr[31:26]`.
- `out_rs`, output, 5: `out_instr[25:21]`.
- `out_rt`, output, 5: `out_instr[20:16]`.
- `out_imm16`, output, 16: `out_instr[15:0]`; feeds the sign extender's 16-bit input.

## Operation
- Storage:
  - Main entry: `main_valid`, `main_instr`, `main_pc`.
  - Skid entry: `skid_valid`, `skid_instr`, `skid_pc`.
- Outputs come from the main entry only. Field outputs are pure slices of `out_instr`.
- Events:
  - `acc = in_valid & in_ready`
  - `pop = main_valid & out_ready`
- State is defined by (main_valid, skid_valid). The combination (0, 1) is illegal and never occurs.
  - EMPTY (0,0):
    - `acc` loads main; go to ONE.
  - ONE (1,0):
    - `acc & pop`: load main with the input; stay in ONE.
    - `acc & !pop`: load skid with the input; go to FULL.
    - `!acc & pop`: go to EMPTY.
    - Otherwise: hold.
  - FULL (1,1): `in_ready=0`, so `acc` is impossible.
    - `pop`: skid moves to main, skid is cleared; go to ONE.
    - Otherwise: hold.
- Flush has top priority. In the cycle `flush=1`, both valids clear at the edge.
  - An `acc` in that cycle is discarded.
  - A `pop` in that cycle is still considered consumed by decode; the stage does not replay it.
- Data registers load only when their entry is written and otherwise hold. Data is not cleared on flush or pop; only valids clear.
- `out_valid` never depends combinationally on `in_valid`. `in_ready` never depends combinationally on `out_ready`.
- Ordering is strict FIFO. No instruction is duplicated or reordered.

## Timing
- Reset, asynchronous and immediate on `reset=1`:
  - `main_valid=0`, `skid_valid=0`, so `out_valid=0` and `in_ready=1`.
  - All instr/pc registers are 0, so `out_instr`, `out_pc` and all field outputs are 0.
- Latency: an instruction accepted at edge N appears on `out_valid` after edge N (visible in cycle N+1), provided main was empty or popping.
- Throughput: 1 instruction/cycle while `out_ready=1`.
- Backpressure: when `out_ready` drops, one more instruction can be accepted (into skid). `in_ready` falls after that edge.
- `in_ready` rises the cycle after the pop that drains skid.
- Reset mid-operation drops all entries immediately. The first accept after deassertion behaves as from EMPTY.
- Flush: `out_valid=0` from the cycle after the flush edge. `in_ready=1` in that same cycle.

## Test plan
- Reset: assert `reset` asynchronously mid-cycle with both entries full.
  - `out_valid=0`, `in_ready=1`, `out_instr=0`, `out_pc=0` immediately.
- Streaming: send 4 instructions on back-to-back cycles with `out_ready=1`.
  - `in_instr=32'h2001FFFC`, PC `0x0`: one cycle later `out_opcode=6'h08`, `out_rs=0`, `out_rt=1`, `out_imm16=16'hFFFC`.
  - The following three are `32'h3C021234`, `32'h8C43FFFF`, `32'hAC430008` with PCs `0x4`, `0x8`, `0xC`.
  - All four appear in order, one per cycle; `in_ready` stays 1.
- Backpressure: `out_ready=0` while sending `0xA`, `0xB`, `0xC` as PCs.
  - `0xA` and `0xB` are accepted; `in_ready=0` after the second accept; `0xC` is held by fetch.
  - With `out_ready=1`, the order is `0xA`, `0xB`, `0xC` with no loss.
- Flush in FULL with simultaneous `in_valid=1`:
  - `out_valid=0` next cycle and the input is not captured.
  - The next accepted PC `0x40` is the first output.
- Flush with simultaneous `pop` in ONE:
  - The popped entry is not re-presented, and `out_valid=0` next cycle.
- Field extraction sweep: random `in_instr`.
  - Check `out_imm16==out_instr[15:0]`, `out_rt==[20:16]`, `out_rs==[25:21]`, `out_opcode==[31:26]` on every valid output.
  - Include `imm16=16'h8000` and `16'h7FFF`, feeding the sign extender as `32'hFFFF8000` and `32'h00007FFF`.
